// File: rtl/clk_ratio_detector.sv
// rtl/clk_ratio_detector.sv - recovers a clock divider's select code from the divided clock
//
// Samples a divided clock on the fast system clock and times the interval
// between successive edges of either polarity. Each interval is mapped back to
// the 2-bit divide-select code that produced it. The block locks once LOCK_CNT
// consecutive identical valid intervals have been seen.
//
// Optional build macro: SYNC_EN
//   Adds a synchronizer flop ahead of the edge detector, so clk_div_in may come
//   from an unrelated clock domain. Every output then moves one cycle later.
//   Measured intervals are unchanged.
//
// Ports:
//   clk        in   fast system clock (the clock that feeds the divider)
//   rst        in   asynchronous active-high reset
//   clk_div_in in   divided clock under measurement
//   x_out      out  recovered select code (00=/4, 01=/8, 10=/16, 11=/32)
//   locked     out  high while x_out is confirmed
//   err        out  one-cycle pulse on an invalid interval or a timeout
//   meas_out   out  last measured half-period, in clk cycles

module clk_ratio_detector #(
  parameter int LOCK_CNT = 3,
  parameter int TIMEOUT  = 40,
  parameter int CW       = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_div_in,
  output logic [1:0]    x_out,
  output logic          locked,
  output logic          err,
  output logic [CW-1:0] meas_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
  localparam logic [2:0]    LC_VAL = 3'(LOCK_CNT);

  // ---------------------------------------------------------------------------
  // Input sampling and edge detection
  // ---------------------------------------------------------------------------
  logic s_q;
  logic s_qq;
  logic div_edge;

`ifdef SYNC_EN
  logic s_meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_meta <= 1'b0;
      s_q    <= 1'b0;
      s_qq   <= 1'b0;
    end else begin
      s_meta <= clk_div_in;
      s_q    <= s_meta;
      s_qq   <= s_q;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q  <= 1'b0;
      s_qq <= 1'b0;
    end else begin
      s_q  <= clk_div_in;
      s_qq <= s_q;
    end
  end
`endif

  // Both polarities count: one edge per half-period of the divided clock.
  assign div_edge = s_q ^ s_qq;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t        state, state_nxt;
  logic [CW-1:0] per_cnt, per_nxt;
  logic [1:0]    cand, cand_nxt;
  logic [2:0]    match_cnt, match_nxt;
  logic [1:0]    x_nxt;
  logic          locked_nxt;
  logic          err_nxt;
  logic [CW-1:0] meas_nxt;

  // On an edge, per_cnt still holds the number of cycles since the previous
  // edge. That value is the measurement.
  logic       meas_valid;
  logic [1:0] meas_code;

  always_comb begin
    meas_valid = 1'b1;
    meas_code  = 2'b00;
    case (per_cnt)
      CW'(2):  meas_code = 2'b00;
      CW'(4):  meas_code = 2'b01;
      CW'(8):  meas_code = 2'b10;
      CW'(16): meas_code = 2'b11;
      default: meas_valid = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  logic upd;

  always_comb begin
    state_nxt  = state;
    per_nxt    = per_cnt;
    cand_nxt   = cand;
    match_nxt  = match_cnt;
    x_nxt      = x_out;
    locked_nxt = locked;
    err_nxt    = 1'b0;
    meas_nxt   = meas_out;
    upd        = 1'b0;

    // Interval counter. It is parked at zero while idle.
    if (state == IDLE) begin
      per_nxt = div_edge ? CW'(1) : '0;
    end else if (div_edge) begin
      per_nxt = CW'(1);
    end else if (per_cnt < TO_VAL) begin
      per_nxt = per_cnt + CW'(1);
    end else begin
      per_nxt = TO_VAL;
    end

    case (state)
      IDLE: begin
        // The first edge only starts the timer. No interval exists yet.
        if (div_edge) begin
          state_nxt = MEASURE;
        end
      end

      MEASURE: begin
        // An edge wins over a coincident timeout. The TIMEOUT-long interval
        // then falls through as an invalid measurement.
        if (div_edge) begin
          meas_nxt = per_cnt;
          upd      = 1'b1;
        end else if (per_cnt == TO_VAL) begin
          err_nxt    = 1'b1;
          locked_nxt = 1'b0;
          match_nxt  = '0;
          per_nxt    = '0;
          state_nxt  = IDLE;
        end
      end

      LOCKED: begin
        if (div_edge) begin
          meas_nxt = per_cnt;
          if (!(meas_valid && (meas_code == x_out))) begin
            // Drop lock but keep x_out at the last confirmed code while
            // a new candidate is qualified.
            locked_nxt = 1'b0;
            state_nxt  = MEASURE;
            upd        = 1'b1;
          end
        end else if (per_cnt == TO_VAL) begin
          err_nxt    = 1'b1;
          locked_nxt = 1'b0;
          match_nxt  = '0;
          per_nxt    = '0;
          state_nxt  = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
        per_nxt   = '0;
      end
    endcase

    // Candidate qualification, shared by MEASURE and by a lock drop.
    if (upd) begin
      if (!meas_valid) begin
        err_nxt   = 1'b1;
        match_nxt = '0;
      end else begin
        if (meas_code == cand) begin
          match_nxt = match_cnt + 3'd1;
        end else begin
          cand_nxt  = meas_code;
          match_nxt = 3'd1;
        end
        if (match_nxt == LC_VAL) begin
          x_nxt      = cand_nxt;
          locked_nxt = 1'b1;
          state_nxt  = LOCKED;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      per_cnt   <= '0;
      cand      <= 2'b00;
      match_cnt <= '0;
      x_out     <= 2'b00;
      locked    <= 1'b0;
      err       <= 1'b0;
      meas_out  <= '0;
    end else begin
      state     <= state_nxt;
      per_cnt   <= per_nxt;
      cand      <= cand_nxt;
      match_cnt <= match_nxt;
      x_out     <= x_nxt;
      locked    <= locked_nxt;
      err       <= err_nxt;
      meas_out  <= meas_nxt;
    end
  end

endmodule

// File: doc/clk_ratio_detector.md
Name: clk_ratio_detector

Overview:
Receive-side counterpart of the team's selectable clock divider. It samples a divided clock on the fast system clock, measures the interval between successive edges, and recovers the 2-bit divide-select code that produced it. It asserts a lock flag once the code is stable. Used on the consuming side of a divided-clock link to confirm or recover the active ratio without a sideband select wire.

Parameters:
LOCK_CNT, 3, consecutive identical valid measurements required to assert locked (1..7)
TIMEOUT, 40, cycles without an edge before lock is dropped (must be > 16, < 2^CW)
CW, 6, interval counter width

Ports:
clk  input  1  fast system clock, same clock that feeds the divider
rst  input  1  asynchronous, active-high reset
clk_div_in  input  1  divided clock under measurement
x_out  output  2  recovered select code (00=/4, 01=/8, 10=/16, 11=/32 period)
locked  output  1  high while x_out is confirmed
err  output  1  one-cycle pulse on an invalid interval or timeout
meas_out  output  CW  last measured half-period in clk cycles

Behaviour:
- Input path: clk_div_in is registered to s_q, then s_q to s_qq. edge = s_q ^ s_qq (either polarity). With SYNC_EN, one extra stage is added first (see below).
- Interval counter per_cnt:
  - Loads 1 on an edge cycle.
  - Otherwise increments, saturating at TIMEOUT.
  - On an edge, the measurement is the value of per_cnt before the load, i.e. the number of cycles since the previous edge.
- Valid intervals are exact: 2 maps to 00, 4 to 01, 8 to 10, 16 to 11. Any other value is invalid.
- Reset values: x_out=00, locked=0, err=0, meas_out=0, per_cnt=0, match_cnt=0, state=IDLE.
- State machine:
  - IDLE: per_cnt is held at 0. The first edge loads per_cnt=1 and moves to MEASURE. No measurement is taken on that edge.
  - MEASURE, on each edge:
    - meas_out is updated with the measurement.
    - Invalid measurement: err pulses, match_cnt=0, stay in MEASURE.
    - Valid code equal to the stored candidate: match_cnt++.
    - Otherwise: candidate=code, match_cnt=1.
    - When match_cnt reaches LOCK_CNT: x_out=candidate, locked=1, go to LOCKED.
  - LOCKED, on each edge:
    - Measurement equal to x_out's interval: hold.
    - Any other measurement: locked=0, err pulses if invalid, candidate/match_cnt reload as in MEASURE, go to MEASURE. x_out holds its last locked value.
  - Timeout: in MEASURE or LOCKED, if per_cnt reaches TIMEOUT with no edge:
    - err pulses, locked=0, match_cnt=0, go to IDLE.
    - An edge arriving in the same cycle takes precedence. It yields measurement TIMEOUT, which is invalid: err, stay/go to MEASURE.
- Timing: all outputs are registered and update the cycle after the edge cycle. err is exactly one cycle wide.
- Latency (no SYNC_EN, LOCK_CNT=3): locked rises 1 cycle after the 4th detected edge following IDLE.
- Reset mid-operation: all state clears immediately (asynchronous). The first post-reset edge is treated as the IDLE start edge.

Optional Feature:
SYNC_EN
- Defined: one additional flop precedes s_q, forming a 2-flop synchronizer so clk_div_in may come from an unrelated domain. Edge detection and all outputs shift 1 cycle later. Measurements are unchanged.
- Undefined: clk_div_in must be synchronous to clk, and only the edge-detect registers are present.

Test Plan:
- Divider x=00 drives clk_div_in after rst release -> meas_out=2; locked=1, x_out=00 one cycle after the 4th edge; err never pulses.
- Sweep x=01, 10, 11 with a rst between runs -> x_out=01/10/11, meas_out=4/8/16, locked=1 after 4 edges each.
- While locked at x=00, switch the divider to x=11 -> locked drops on the first mismatching interval (err pulses if that interval is invalid); x_out stays 00 until 3 intervals of 16 are seen, then x_out=11 and locked=1.
- Stop clk_div_in (hold 0) while locked -> err pulses exactly once when per_cnt reaches 40; locked=0; state IDLE; x_out retains its value.
- Inject intervals of 3, then 2, 2, 2 -> err pulse on the 3; lock at x_out=00 after the three 2s.
- Assert rst for 1 cycle mid-measurement, asynchronously to clk -> outputs zero immediately; relock takes the full 4 edges. With SYNC_EN defined, all of the above timings shift +1 cycle.
